mem_bus_arbiter: RTL

//   Shares the single data-memory/MIO bus between two requesters: port 0 (SCPU load/store;
//   m0_ready drives SCPU MIO_ready) and port 1 (auxiliary master, e.g. DMA/debug loader).

---
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the two requester ports and the shared memory bus of mem_bus_arbiter.
//   slave  : arbiter view (takes m0/m1 requests, drives the memory bus, gnt, bus_err)
//   master : environment view (requesters + memory responder)
//   Port 0 / port 1: *_req, *_we, *_addr, *_wdata -> arbiter; *_rdata, *_ready <- arbiter
//   Memory:          mem_req, mem_we, mem_addr, mem_wdata <- arbiter; mem_rdata, mem_ack -> arbiter
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req, m0_we, m0_ready;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;

  logic          m1_req, m1_we, m1_ready;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;

  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [1:0]    gnt;
  logic          bus_err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ready,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output gnt, bus_err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  gnt, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one data-memory/MIO bus between port 0 (SCPU load/store) and port 1
//   (auxiliary master). Round-robin grant, latched transaction, mem_req/mem_ack
//   handshake, per-port read-data holding registers, and a watchdog that aborts
//   an access after TIMEOUT BUSY cycles without mem_ack.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mem_bus_arbiter_if.slave (AW/DW of the interface must match this module)
//        m*_ready : 1-cycle completion pulse to the granted port
//        m*_rdata : holds the last completed read of that port
//        gnt      : one-hot {m1,m0} from grant through DONE, 0 in IDLE
//        bus_err  : pulses with ready when the access was aborted
module mem_bus_arbiter #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_SAT  = WDW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t             state;
  logic [1:0]         req;
  req_t [1:0]         rq;
  req_t               cur;          // latched copy driving the memory bus
  logic [1:0][DW-1:0] rdata;
  logic [1:0]         ready, gnt;
  logic               mem_req, bus_err;
  logic               last_grant;   // also selects the owner of the current access
  logic               win;
  logic [WDW-1:0]     wd;

  assign req   = {bus.m1_req, bus.m0_req};
  assign rq[0] = {bus.m0_we, bus.m0_addr, bus.m0_wdata};
  assign rq[1] = {bus.m1_we, bus.m1_addr, bus.m1_wdata};

  // On a tie the port that did not win last time goes; last_grant resets to 1
  // so port 0 wins the first tie.
  always_comb begin
    win = req[1];
    if (&req) win = ~last_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      mem_req    <= 1'b0;
      gnt        <= '0;
      ready      <= '0;
      bus_err    <= 1'b0;
      rdata      <= '0;
      last_grant <= 1'b1;
      wd         <= '0;
    end else begin
      ready   <= '0;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state      <= BUSY;
          cur        <= rq[win];
          mem_req    <= 1'b1;
          gnt        <= win ? 2'b10 : 2'b01;
          last_grant <= win;
          wd         <= '0;
        end
        BUSY: begin
          // ack is checked first so an ack on the final watchdog cycle still succeeds
          if (bus.mem_ack) begin
            state             <= DONE;
            mem_req           <= 1'b0;
            ready[last_grant] <= 1'b1;
            if (!cur.we) rdata[last_grant] <= bus.mem_rdata;
          end else if (wd == WD_LAST) begin
            state             <= DONE;
            mem_req           <= 1'b0;
            ready[last_grant] <= 1'b1;
            bus_err           <= 1'b1;
            if (!cur.we) rdata[last_grant] <= ERR_DATA;
          end else if (wd != WD_SAT) begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          // one turnaround cycle so a requester can drop req before re-arbitration
          state <= IDLE;
          gnt   <= '0;
          wd    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = cur.we;
  assign bus.mem_addr  = cur.addr;
  assign bus.mem_wdata = cur.wdata;
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];
  assign bus.m0_ready  = ready[0];
  assign bus.m1_ready  = ready[1];
  assign bus.gnt       = gnt;
  assign bus.bus_err   = bus_err;
endmodule
